// File: rtl/raminfr_dp_param.sv
// rtl/raminfr_dp_param.sv - dual-port inferred RAM with power-up/clear zero sweep
//
// Purpose: DEPTH = 2**AW words of DW bits. Port A (a/di/we) writes and reads
// read-first. Port B (dpra/dpre) is a read-only port with selectable
// read-during-write behaviour. After reset, and on a clr request, an internal
// counter sweeps zeros through every word before user access is accepted.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst_n    - asynchronous active-low reset
//   we       - port A write enable
//   a        - port A address (write and read)
//   di       - port A write data
//   dpra     - port B read address
//   dpre     - port B read enable
//   clr      - one-cycle request to re-run the zero sweep
//   spo      - port A read data
//   dpo      - port B read data (held between enabled reads)
//   dpo_vld  - dpo carries data for a dpre-qualified read
//   busy     - zero sweep in progress
module raminfr_dp_param #(
    parameter int DW       = 4,
    parameter int AW       = 5,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] di,
    input  logic [AW-1:0] dpra,
    input  logic          dpre,
    input  logic          clr,
    output logic [DW-1:0] spo,
    output logic [DW-1:0] dpo,
    output logic          dpo_vld,
    output logic          busy
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // Array is deliberately outside the reset domain; zeros come from the sweep.
    logic [DW-1:0] mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic [DW-1:0] spo1_q, spo1_d;
    logic [DW-1:0] dpo1_q, dpo1_d;
    logic          vld1_q, vld1_d;

    logic          run;
    logic          user_we;
    logic          flush;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;

    always_comb begin
        run       = (state_q == ST_RUN);
        user_we   = run & we;
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (run) begin
            cnt_d = '0;
            if (clr) begin
                state_d = ST_INIT;
            end
        end else begin
            cnt_d = cnt_q + AW'(1);
            if (&cnt_q) begin
                state_d = ST_RUN;
            end
        end

        // A write on the clr edge still lands; the sweep overwrites it later.
        mem_we    = !run | user_we;
        mem_waddr = run ? a : cnt_q;
        mem_wdata = run ? di : '0;

        rd_a = mem_q[a];
        if ((RDW_MODE != 0) && user_we && (dpra == a)) begin
            rd_b = di;
        end else begin
            rd_b = mem_q[dpra];
        end

        // Zero the pipeline for anything sampled while sweeping and for the
        // read taken on the clr edge, whose result would otherwise show while busy.
        flush  = !run || (state_d == ST_INIT);
        spo1_d = flush ? '0 : rd_a;
        dpo1_d = flush ? '0 : (dpre ? rd_b : dpo1_q);
        vld1_d = !flush && dpre;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            spo1_q  <= '0;
            dpo1_q  <= '0;
            vld1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spo1_q  <= spo1_d;
            dpo1_q  <= dpo1_d;
            vld1_q  <= vld1_d;
        end
    end

    assign busy = (state_q == ST_INIT);

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] spo2_q, spo2_d;
            logic [DW-1:0] dpo2_q, dpo2_d;
            logic          vld2_q, vld2_d;

            // Data and valid move together so they stay aligned at the output.
            always_comb begin
                spo2_d = flush ? '0 : spo1_q;
                dpo2_d = flush ? '0 : dpo1_q;
                vld2_d = !flush && vld1_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    spo2_q <= '0;
                    dpo2_q <= '0;
                    vld2_q <= 1'b0;
                end else begin
                    spo2_q <= spo2_d;
                    dpo2_q <= dpo2_d;
                    vld2_q <= vld2_d;
                end
            end

            assign spo     = spo2_q;
            assign dpo     = dpo2_q;
            assign dpo_vld = vld2_q;
        end else begin : g_no_out_reg
            assign spo     = spo1_q;
            assign dpo     = dpo1_q;
            assign dpo_vld = vld1_q;
        end
    endgenerate

endmodule

// File: tb/tb_raminfr_dp_param.sv
// tb/tb_raminfr_dp_param.sv - scoreboard bench for raminfr_dp_param
module tb_raminfr_dp_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we, dpre, clr;
    logic [4:0] a, dpra;
    logic [3:0] di;
    logic [3:0] spo0, dpo0, spo1, dpo1;
    logic       vld0, busy0, vld1, busy1;

    logic       we2, dpre2, clr2;
    logic [3:0] a2, dpra2;
    logic [7:0] di2, spo2, dpo2;
    logic       vld2, busy2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        int         due;
        logic [7:0] val;
    } exp_t;

    exp_t dq0[$];
    exp_t dq1[$];
    exp_t dq2[$];
    exp_t sq[$];

    raminfr_dp_param u_dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .a(a), .di(di), .dpra(dpra),
        .dpre(dpre), .clr(clr), .spo(spo0), .dpo(dpo0), .dpo_vld(vld0), .busy(busy0)
    );

    raminfr_dp_param #(.RDW_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .a(a), .di(di), .dpra(dpra),
        .dpre(dpre), .clr(clr), .spo(spo1), .dpo(dpo1), .dpo_vld(vld1), .busy(busy1)
    );

    raminfr_dp_param #(.DW(8), .AW(4), .OUT_REG(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .we(we2), .a(a2), .di(di2), .dpra(dpra2),
        .dpre(dpre2), .clr(clr2), .spo(spo2), .dpo(dpo2), .dpo_vld(vld2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    task automatic push_dpo(input int id, input logic [7:0] v, input int lat);
        exp_t e;
        e.id = id; e.due = cyc + lat; e.val = v;
        case (id)
            0: dq0.push_back(e);
            1: dq1.push_back(e);
            default: dq2.push_back(e);
        endcase
    endtask

    task automatic push_spo(input int id, input logic [7:0] v, input int lat);
        exp_t e;
        e.id = id; e.due = cyc + lat; e.val = v;
        sq.push_back(e);
    endtask

    task automatic pop_dpo(input int id);
        case (id)
            0: dq0.delete(0);
            1: dq1.delete(0);
            default: dq2.delete(0);
        endcase
    endtask

    task automatic mon_dpo(input int id, input logic vld, input logic [7:0] val);
        exp_t e;
        int   n;
        n = 0; e.id = 0; e.due = 0; e.val = '0;
        case (id)
            0: begin n = dq0.size(); if (n > 0) e = dq0[0]; end
            1: begin n = dq1.size(); if (n > 0) e = dq1[0]; end
            default: begin n = dq2.size(); if (n > 0) e = dq2[0]; end
        endcase
        if (vld) begin
            checks++;
            if (n == 0) begin
                errors++;
                $display("FAIL dpo%0d_unexpected_valid cyc=%0d got=%h", id, cyc, val);
            end else begin
                if (e.due != cyc || e.val !== val) begin
                    errors++;
                    $display("FAIL dpo%0d_read cyc=%0d got=%h due=%0d expected=%h",
                             id, cyc, val, e.due, e.val);
                end
                pop_dpo(id);
            end
        end else if (n > 0 && e.due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL dpo%0d_missing_valid cyc=%0d due=%0d expected=%h", id, cyc, e.due, e.val);
            pop_dpo(id);
        end
    endtask

    task automatic monitor_step();
        exp_t       e;
        logic [7:0] got;
        if (busy0) chk("busy_zero_out_dut0", {spo0, dpo0}, 8'h00);
        if (busy1) chk("busy_zero_out_dut1", {spo1, dpo1}, 8'h00);
        if (busy2) chk("busy_zero_out_dut2", spo2 | dpo2, 8'h00);
        mon_dpo(0, vld0, {4'h0, dpo0});
        mon_dpo(1, vld1, {4'h0, dpo1});
        mon_dpo(2, vld2, dpo2);
        for (int i = sq.size() - 1; i >= 0; i--) begin
            if (sq[i].due <= cyc) begin
                e   = sq[i];
                got = (e.id == 0) ? {4'h0, spo0} : (e.id == 1) ? {4'h0, spo1} : spo2;
                checks++;
                if (e.due != cyc || got !== e.val) begin
                    errors++;
                    $display("FAIL spo%0d_read cyc=%0d got=%h due=%0d expected=%h",
                             e.id, cyc, got, e.due, e.val);
                end
                sq.delete(i);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Fixed window; junk traffic is driven into each DUT only while it reports busy.
    task automatic count_busy(output int n0, output int n1, output int n2);
        n0 = 0; n1 = 0; n2 = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (busy0) n0++;
            if (busy1) n1++;
            if (busy2) n2++;
            #1;
            if (busy0) begin
                we = 1'b1; a = 5'(k - 1); di = 4'hF; dpre = 1'b1; dpra = 5'(k); clr = 1'b1;
            end else begin
                we = 1'b0; dpre = 1'b0; clr = 1'b0;
            end
            if (busy2) begin
                we2 = 1'b1; a2 = 4'(k - 1); di2 = 8'hFF; dpre2 = 1'b1; dpra2 = 4'(k);
            end else begin
                we2 = 1'b0; dpre2 = 1'b0;
            end
        end
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 32; i++) begin
            step();
            we = 1'b0; a = 5'(i); dpra = 5'(i); dpre = 1'b1;
            push_dpo(0, 8'h00, 1); push_dpo(1, 8'h00, 1);
            push_spo(0, 8'h00, 1); push_spo(1, 8'h00, 1);
        end
        step();
        dpre = 1'b0;
    endtask

    task automatic check_busy(input string tag, input int e0, input int e2);
        int n0, n1, n2;
        count_busy(n0, n1, n2);
        chk({tag, "_busy_dut0"}, 8'(n0), 8'(e0));
        chk({tag, "_busy_dut1"}, 8'(n1), 8'(e0));
        chk({tag, "_busy_dut2"}, 8'(n2), 8'(e2));
    endtask

    initial begin
        rst_n = 1'b0;
        we = 0; dpre = 0; clr = 0; a = '0; dpra = '0; di = '0;
        we2 = 0; dpre2 = 0; clr2 = 0; a2 = '0; dpra2 = '0; di2 = '0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_dut0", {spo0, dpo0}, 8'h00);
        chk("reset_vld_busy_dut0", {6'b0, vld0, busy0}, 8'h01);
        chk("reset_out_dut2", spo2 | dpo2, 8'h00);
        chk("reset_vld_busy_dut2", {6'b0, vld2, busy2}, 8'h01);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_busy("power_up", 32, 16);
        read_all_zero();

        // Basic write then read on both ports.
        step(); we = 1; a = 5; di = 4'hA; dpre = 0;
        push_spo(0, 8'h00, 1); push_spo(1, 8'h00, 1);
        step(); we = 0; a = 5; dpre = 1; dpra = 5;
        push_spo(0, 8'h0A, 1); push_spo(1, 8'h0A, 1);
        push_dpo(0, 8'h0A, 1); push_dpo(1, 8'h0A, 1);
        // Write elsewhere while port B reads address 5.
        step(); we = 1; a = 4; di = 4'h9; dpre = 1; dpra = 5;
        push_spo(0, 8'h00, 1); push_spo(1, 8'h00, 1);
        push_dpo(0, 8'h0A, 1); push_dpo(1, 8'h0A, 1);
        step(); we = 0; a = 4; dpre = 1; dpra = 4;
        push_spo(0, 8'h09, 1); push_spo(1, 8'h09, 1);
        push_dpo(0, 8'h09, 1); push_dpo(1, 8'h09, 1);
        // Collision on address 3.
        step(); we = 1; a = 3; di = 4'h1; dpre = 0;
        push_spo(0, 8'h00, 1); push_spo(1, 8'h00, 1);
        step(); we = 1; a = 3; di = 4'h7; dpre = 1; dpra = 3;
        push_spo(0, 8'h01, 1); push_spo(1, 8'h01, 1);
        push_dpo(0, 8'h01, 1); push_dpo(1, 8'h07, 1);
        step(); we = 0; a = 3; dpre = 1; dpra = 3;
        push_spo(0, 8'h07, 1); push_spo(1, 8'h07, 1);
        push_dpo(0, 8'h07, 1); push_dpo(1, 8'h07, 1);
        step(); dpre = 0; dpra = 0;
        step();
        step();
        chk("dpo_hold_dut0", {3'b0, vld0, dpo0}, 8'h07);
        chk("dpo_hold_dut1", {3'b0, vld1, dpo1}, 8'h07);

        // Asynchronous reset while a read result is on the outputs.
        dpre = 1; dpra = 3;
        @(posedge clk);
        #2;
        chk("pre_reset_dut0", {3'b0, vld0, dpo0}, 8'h17);
        rst_n = 1'b0;
        dpre = 0;
        #1;
        chk("async_reset_out_dut0", {spo0, dpo0}, 8'h00);
        chk("async_reset_vld_busy_dut0", {6'b0, vld0, busy0}, 8'h01);
        chk("async_reset_out_dut1", {spo1, dpo1}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_busy("run_reset", 32, 16);

        // Clear request together with a write; the write is swept away.
        step(); clr = 1; we = 1; a = 2; di = 4'hF; dpre = 0;
        check_busy("clr", 32, 0);
        read_all_zero();

        // Reset while the sweep counter is 10.
        step(); clr = 1; we = 0; dpre = 0;
        @(posedge clk);
        #1;
        clr = 0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_sweep_reset_dut0", {3'b0, vld0, spo0 | dpo0}, 8'h00);
        chk("mid_sweep_reset_busy", {6'b0, busy0, busy2}, 8'h03);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_busy("mid_sweep", 32, 16);
        read_all_zero();

        // Registered-output instance: two-cycle latency.
        step(); we2 = 1; a2 = 9; di2 = 8'h5C; dpre2 = 0;
        push_spo(2, 8'h00, 2);
        step(); we2 = 1; a2 = 15; di2 = 8'hA7; dpre2 = 1; dpra2 = 9;
        push_spo(2, 8'h00, 2); push_dpo(2, 8'h5C, 2);
        step(); we2 = 0; a2 = 9; dpre2 = 1; dpra2 = 15;
        push_spo(2, 8'h5C, 2); push_dpo(2, 8'hA7, 2);
        step(); a2 = 15; dpre2 = 1; dpra2 = 3;
        push_spo(2, 8'hA7, 2); push_dpo(2, 8'h00, 2);
        step(); dpre2 = 0;

        repeat (6) step();
        chk("scoreboard_drained", 8'(dq0.size() + dq1.size() + dq2.size() + sq.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
